// File: rtl/branch_predictor_unit.sv
// Dynamic branch predictor: saturating-counter direction table plus a direct-mapped BTB,
// with optional gshare indexing. Combinational lookup, registered training from EX/MEM.
module branch_predictor_unit #(
  parameter int ENTRIES  = 64,
  parameter int CTR_BITS = 2,
  parameter int GHR_BITS = 4,
  parameter int MODE     = 0,
  parameter int ADDR_W   = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [ADDR_W-1:0] lk_pc_i,
  output logic              pred_hit_o,
  output logic              pred_taken_o,
  output logic [ADDR_W-1:0] pred_target_o,
  input  logic              upd_valid_i,
  input  logic [ADDR_W-1:0] upd_pc_i,
  input  logic              upd_taken_i,
  input  logic [ADDR_W-1:0] upd_target_i,
  output logic              busy_o
);

  localparam int IDX   = $clog2(ENTRIES);
  localparam int TAG_W = ADDR_W - IDX - 2;
  localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);
  localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;
  localparam logic [IDX-1:0]      LAST_IDX = IDX'(ENTRIES - 1);

  typedef enum logic {ST_INIT, ST_RUN} state_e;

  state_e              state_q, state_d;
  logic [IDX-1:0]      cursor_q, cursor_d;
  logic [GHR_BITS-1:0] ghr_q, ghr_d;

  // Tables carry no reset; the INIT sweep is what makes them defined.
  logic                valid_q [ENTRIES];
  logic [TAG_W-1:0]    tag_q   [ENTRIES];
  logic [ADDR_W-1:0]   tgt_q   [ENTRIES];
  logic [CTR_BITS-1:0] ctr_q   [ENTRIES];

  logic sweep_we, upd_en, run;

  function automatic logic [IDX-1:0] ctr_index(input logic [IDX-1:0] bidx,
                                               input logic [GHR_BITS-1:0] hist);
    if (MODE == 1) return bidx ^ IDX'(hist);
    else           return bidx;
  endfunction

  // Lookup path
  logic [IDX-1:0]   lk_bidx, lk_cidx;
  logic [TAG_W-1:0] lk_tag;
  logic             lk_match;

  assign lk_bidx  = lk_pc_i[IDX+1:2];
  assign lk_tag   = lk_pc_i[ADDR_W-1:IDX+2];
  assign lk_cidx  = ctr_index(lk_bidx, ghr_q);
  assign lk_match = run && valid_q[lk_bidx] && (tag_q[lk_bidx] == lk_tag);

  assign pred_hit_o    = lk_match;
  assign pred_taken_o  = lk_match && ctr_q[lk_cidx][CTR_BITS-1];
  assign pred_target_o = lk_match ? tgt_q[lk_bidx] : '0;

  // Update path; counter index uses the history before this update shifts it
  logic [IDX-1:0]      up_bidx, up_cidx;
  logic [TAG_W-1:0]    up_tag;
  logic [CTR_BITS-1:0] up_ctr, up_ctr_nxt;

  assign up_bidx = upd_pc_i[IDX+1:2];
  assign up_tag  = upd_pc_i[ADDR_W-1:IDX+2];
  assign up_cidx = ctr_index(up_bidx, ghr_q);
  assign up_ctr  = ctr_q[up_cidx];

  always_comb begin
    up_ctr_nxt = up_ctr;
    if (upd_taken_i) begin
      if (up_ctr != CTR_MAX) up_ctr_nxt = up_ctr + 1'b1;
    end else begin
      if (up_ctr != '0) up_ctr_nxt = up_ctr - 1'b1;
    end
  end

  // FSM: state register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= ST_INIT;
      cursor_q <= '0;
      ghr_q    <= '0;
    end else begin
      state_q  <= state_d;
      cursor_q <= cursor_d;
      ghr_q    <= ghr_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d  = state_q;
    cursor_d = cursor_q;
    ghr_d    = ghr_q;
    case (state_q)
      ST_INIT: begin
        cursor_d = cursor_q + 1'b1;
        if (cursor_q == LAST_IDX) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (upd_valid_i) ghr_d = GHR_BITS'({ghr_q, upd_taken_i});
      end
      default: state_d = ST_INIT;
    endcase
  end

  // FSM: outputs and table write enables
  always_comb begin
    run      = (state_q == ST_RUN);
    busy_o   = (state_q != ST_RUN);
    sweep_we = (state_q == ST_INIT);
    upd_en   = (state_q == ST_RUN) && upd_valid_i && !rst_i;
  end

  always_ff @(posedge clk_i) begin
    if (sweep_we) begin
      valid_q[cursor_q] <= 1'b0;
      ctr_q[cursor_q]   <= CTR_INIT;
    end else if (upd_en) begin
      ctr_q[up_cidx] <= up_ctr_nxt;
      if (upd_taken_i) begin
        valid_q[up_bidx] <= 1'b1;
        tag_q[up_bidx]   <= up_tag;
        tgt_q[up_bidx]   <= upd_target_i;
      end
    end
  end

  // Word-aligned PCs: the byte-offset bits carry no information
  logic unused_pc_lsbs;
  assign unused_pc_lsbs = ^{lk_pc_i[1:0], upd_pc_i[1:0]};

endmodule
